// File: rtl/ad9648_spi_master_pkg.sv
// rtl/ad9648_spi_master_pkg.sv - shared FSM states, default sizing and AD9648 register constants
package ad9648_spi_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_e;

    localparam int DEF_TX_REG_WIDTH = 24;
    localparam int DEF_RX_REG_WIDTH = 8;
    localparam int DEF_CLK_DIV      = 4;
    localparam int DEF_CS_SETUP     = 2;
    localparam int DEF_CS_HOLD      = 2;

    // AD9648 instruction word: R/W, W1:W0 (single byte = 00), 13-bit address
    localparam int          AD_RW_BIT        = 23;
    localparam int          AD_INSTR_WIDTH   = 16;
    localparam logic [12:0] AD_ADDR_CHIP_ID  = 13'h001;
    localparam logic [12:0] AD_ADDR_TRANSFER = 13'h0FF;

    function automatic logic [15:0] ad_instr(input logic rd, input logic [12:0] addr);
        return {rd, 2'b00, addr};
    endfunction

endpackage

// File: rtl/ad9648_spi_master_if.sv
// rtl/ad9648_spi_master_if.sv - register-access handshake between control_fsm and the SPI master
interface ad9648_spi_master_if
    import ad9648_spi_master_pkg::*;
#(
    parameter int TxRegWidth = DEF_TX_REG_WIDTH,
    parameter int RxRegWidth = DEF_RX_REG_WIDTH
);
    logic [TxRegWidth-1:0] tx_reg;
    logic                  transfer_start;
    logic [RxRegWidth-1:0] rx_reg;
    logic                  transfer_done;
    logic                  busy;

    modport master (
        output tx_reg, transfer_start,
        input  rx_reg, transfer_done, busy
    );

    modport slave (
        input  tx_reg, transfer_start,
        output rx_reg, transfer_done, busy
    );

endinterface

// File: rtl/ad9648_spi_master_clk_gen.sv
// rtl/ad9648_spi_master_clk_gen.sv - SCLK divider with single-cycle rise/fall strobes
module ad9648_spi_master_clk_gen #(
    parameter int ClkDiv = 4
) (
    input  logic clk_i,
    input  logic rst_clk_n_i,
    input  logic en,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);
    localparam int CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

    logic [CntW-1:0] div_cnt;
    logic            tick;

    // Strobes flag the clk_i cycle whose closing edge flips SCLK
    assign tick     = en && (div_cnt == CntW'(ClkDiv - 1));
    assign rise_stb = tick && !sclk;
    assign fall_stb = tick && sclk;

    always_ff @(posedge clk_i or negedge rst_clk_n_i) begin
        if (!rst_clk_n_i) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ad9648_spi_master.sv
// rtl/ad9648_spi_master.sv - 3-wire SPI master for AD9648 register reads and writes
module ad9648_spi_master
    import ad9648_spi_master_pkg::*;
#(
    parameter int TxRegWidth = DEF_TX_REG_WIDTH,
    parameter int RxRegWidth = DEF_RX_REG_WIDTH,
    parameter int ClkDiv     = DEF_CLK_DIV,
    parameter int CsSetup    = DEF_CS_SETUP,
    parameter int CsHold     = DEF_CS_HOLD
) (
    input  logic                clk_i,
    input  logic                rst_clk_n_i,
    ad9648_spi_master_if.slave  ctrl,
    output logic                spi_sclk_o,
    output logic                spi_csb_o,
    output logic                spi_sdio_o,
    output logic                spi_sdio_t_o,
    input  logic                spi_sdio_i
);
    localparam int InstrBits = TxRegWidth - RxRegWidth;
    localparam int BitW      = $clog2(TxRegWidth + 1);
    localparam int DlyMax    = (CsSetup > CsHold) ? CsSetup : CsHold;
    localparam int DlyW      = $clog2(DlyMax + 1);

    spi_state_e            state_q, state_d;
    logic [TxRegWidth-1:0] tx_shift_q;
    logic [RxRegWidth-1:0] rx_shift_q;
    logic [RxRegWidth-1:0] rx_reg_q;
    logic [BitW-1:0]       bit_cnt_q;
    logic [DlyW-1:0]       dly_cnt_q;
    logic                  is_read_q;
    logic                  turn_q;
    logic                  done_q;
    logic                  busy;
    logic                  rise_stb, fall_stb;
    logic                  start_ok, setup_last, hold_last, shift_last;

    ad9648_spi_master_clk_gen #(.ClkDiv(ClkDiv)) u_clk_gen (
        .clk_i       (clk_i),
        .rst_clk_n_i (rst_clk_n_i),
        .en          (state_q == ST_SHIFT),
        .sclk        (spi_sclk_o),
        .rise_stb    (rise_stb),
        .fall_stb    (fall_stb)
    );

    // A start coinciding with the done pulse is dropped, not queued
    assign start_ok   = ctrl.transfer_start && !done_q;
    assign setup_last = (dly_cnt_q == DlyW'(CsSetup - 1));
    assign hold_last  = (dly_cnt_q == DlyW'(CsHold - 1));
    assign shift_last = fall_stb && (bit_cnt_q == BitW'(TxRegWidth));

    always_ff @(posedge clk_i or negedge rst_clk_n_i) begin
        if (!rst_clk_n_i) state_q <= ST_IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok)   state_d = ST_SETUP;
            ST_SETUP: if (setup_last) state_d = ST_SHIFT;
            ST_SHIFT: if (shift_last) state_d = ST_HOLD;
            ST_HOLD:  if (hold_last)  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        spi_csb_o    = (state_q == ST_IDLE);
        spi_sdio_t_o = (state_q == ST_IDLE) || turn_q;
        spi_sdio_o   = (state_q != ST_IDLE) && tx_shift_q[TxRegWidth-1];
        busy         = (state_q != ST_IDLE) || done_q;
    end

    assign ctrl.rx_reg        = rx_reg_q;
    assign ctrl.transfer_done = done_q;
    assign ctrl.busy          = busy;

    always_ff @(posedge clk_i or negedge rst_clk_n_i) begin
        if (!rst_clk_n_i) begin
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_reg_q   <= '0;
            bit_cnt_q  <= '0;
            dly_cnt_q  <= '0;
            is_read_q  <= 1'b0;
            turn_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_q == ST_HOLD) && hold_last;
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        tx_shift_q <= ctrl.tx_reg;
                        is_read_q  <= ctrl.tx_reg[TxRegWidth-1];
                        turn_q     <= 1'b0;
                        bit_cnt_q  <= '0;
                        dly_cnt_q  <= '0;
                    end
                end
                ST_SETUP: begin
                    dly_cnt_q <= setup_last ? '0 : dly_cnt_q + 1'b1;
                end
                ST_SHIFT: begin
                    // bit_cnt_q holds the number of rises seen so far
                    if (rise_stb) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (is_read_q && (bit_cnt_q >= BitW'(InstrBits)))
                            rx_shift_q <= {rx_shift_q[RxRegWidth-2:0], spi_sdio_i};
                    end
                    if (fall_stb) begin
                        tx_shift_q <= tx_shift_q << 1;
                        if (is_read_q && (bit_cnt_q == BitW'(InstrBits)))
                            turn_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    dly_cnt_q <= hold_last ? '0 : dly_cnt_q + 1'b1;
                    if (hold_last && is_read_q) rx_reg_q <= rx_shift_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ad9648_spi_master.sv
// tb/tb_ad9648_spi_master.sv - directed self-checking bench for ad9648_spi_master
module tb_ad9648_spi_master;
    import ad9648_spi_master_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic sdio_i;
    bit   sel;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    ad9648_spi_master_if #(.TxRegWidth(24), .RxRegWidth(8)) ctrl_d ();
    ad9648_spi_master_if #(.TxRegWidth(24), .RxRegWidth(8)) ctrl_f ();

    logic sclk_d, csb_d, sdo_d, sdt_d;
    logic sclk_f, csb_f, sdo_f, sdt_f;

    ad9648_spi_master #(.TxRegWidth(24), .RxRegWidth(8), .ClkDiv(4), .CsSetup(2), .CsHold(2)) dut (
        .clk_i        (clk),
        .rst_clk_n_i  (rst_n),
        .ctrl         (ctrl_d.slave),
        .spi_sclk_o   (sclk_d),
        .spi_csb_o    (csb_d),
        .spi_sdio_o   (sdo_d),
        .spi_sdio_t_o (sdt_d),
        .spi_sdio_i   (sdio_i)
    );

    ad9648_spi_master #(.TxRegWidth(24), .RxRegWidth(8), .ClkDiv(1), .CsSetup(1), .CsHold(1)) dut_fast (
        .clk_i        (clk),
        .rst_clk_n_i  (rst_n),
        .ctrl         (ctrl_f.slave),
        .spi_sclk_o   (sclk_f),
        .spi_csb_o    (csb_f),
        .spi_sdio_o   (sdo_f),
        .spi_sdio_t_o (sdt_f),
        .spi_sdio_i   (sdio_i)
    );

    wire       m_sclk = sel ? sclk_f : sclk_d;
    wire       m_csb  = sel ? csb_f  : csb_d;
    wire       m_sdo  = sel ? sdo_f  : sdo_d;
    wire       m_sdt  = sel ? sdt_f  : sdt_d;
    wire       m_done = sel ? ctrl_f.transfer_done : ctrl_d.transfer_done;
    wire [7:0] m_rx   = sel ? ctrl_f.rx_reg : ctrl_d.rx_reg;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive(input logic [23:0] tx, input logic st);
        if (sel) begin
            ctrl_f.tx_reg = tx;
            ctrl_f.transfer_start = st;
        end else begin
            ctrl_d.tx_reg = tx;
            ctrl_d.transfer_start = st;
        end
    endtask

    // Starts a frame and plays the ADC side; cycle 0 is the start cycle
    task automatic run_frame(input bit s, input logic [23:0] tx, input logic [7:0] sdat, input int mid_start,
                             output int rises, output logic [23:0] cap, output int done_cyc,
                             output int n_done, output bit t_err, output logic [7:0] rx_done,
                             output logic csb_done, output int gap);
        bit is_rd, prev, seen_low;
        int falls;
        sel = s;
        is_rd = tx[AD_RW_BIT];
        rises = 0; falls = 0; cap = '0; done_cyc = -1; n_done = 0; t_err = 0;
        rx_done = '0; csb_done = 1'b0; gap = 0; prev = 1'b0; seen_low = 1'b0;
        @(negedge clk);
        if (m_csb) gap = 1;
        drive(tx, 1'b1);
        for (int c = 1; c <= 400 && done_cyc < 0; c++) begin
            @(negedge clk);
            drive((c == mid_start) ? 24'hFFFFFF : tx, c == mid_start);
            if (!seen_low) begin
                if (m_csb) gap++;
                else seen_low = 1'b1;
            end
            if (m_sclk && !prev) begin
                rises++;
                cap = {cap[22:0], m_sdo};
            end
            if (!m_sclk && prev) begin
                falls++;
                if (is_rd && falls >= AD_INSTR_WIDTH && falls < 24) sdio_i = sdat[3'(23 - falls)];
            end
            if (!m_csb && (m_sdt !== (is_rd && falls >= AD_INSTR_WIDTH))) t_err = 1'b1;
            if (m_done) begin
                n_done++;
                done_cyc = c;
                rx_done = m_rx;
                csb_done = m_csb;
            end
            prev = m_sclk;
        end
        drive(tx, 1'b0);
        sdio_i = 1'b0;
    endtask

    initial begin
        int         rises, done_cyc, n_done, gap, extra;
        logic [23:0] cap;
        bit         t_err, prev;
        logic [7:0] rx;
        logic       csb;

        rst_n = 1'b0;
        sdio_i = 1'b0;
        sel = 1'b0;
        ctrl_d.tx_reg = '0; ctrl_d.transfer_start = 1'b0;
        ctrl_f.tx_reg = '0; ctrl_f.transfer_start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_csb",  csb_d, 1);
        check("rst_sclk", sclk_d, 0);
        check("rst_sdo",  sdo_d, 0);
        check("rst_sdt",  sdt_d, 1);
        check("rst_busy", ctrl_d.busy, 0);
        check("rst_done", ctrl_d.transfer_done, 0);
        check("rst_rx",   ctrl_d.rx_reg, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write addr 0x008 data 0x14
        run_frame(1'b0, 24'h000814, 8'h00, 0, rises, cap, done_cyc, n_done, t_err, rx, csb, gap);
        check("w_rises",    rises, 24);
        check("w_addr",     cap[20:8], 13'h008);
        check("w_data",     cap[7:0], 8'h14);
        check("w_sdt",      t_err, 0);
        check("w_done_cyc", done_cyc, 197);
        check("w_rx",       rx, 0);
        check("w_csb_done", csb, 1);
        check("w_busy_done", ctrl_d.busy, 1);

        // Start raised during the done cycle must be dropped
        drive(24'h000814, 1'b1);
        @(negedge clk);
        drive(24'h000814, 1'b0);
        check("done_start_busy", ctrl_d.busy, 0);
        check("done_start_csb",  csb_d, 1);

        // Read chip ID, ADC returns 0x88
        run_frame(1'b0, {ad_instr(1'b1, AD_ADDR_CHIP_ID), 8'h00}, 8'h88, 0,
                  rises, cap, done_cyc, n_done, t_err, rx, csb, gap);
        check("r_instr",    cap[23:8], 16'h8001);
        check("r_sdt",      t_err, 0);
        check("r_rx",       rx, 8'h88);
        check("r_done_cyc", done_cyc, 197);

        // Stray start at cycle 50 of a write frame
        run_frame(1'b0, {ad_instr(1'b0, AD_ADDR_TRANSFER), 8'h01}, 8'h00, 50,
                  rises, cap, done_cyc, n_done, t_err, rx, csb, gap);
        extra = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (ctrl_d.transfer_done || ctrl_d.busy) extra++;
        end
        check("m_addr",    cap[20:8], 13'h0FF);
        check("m_data",    cap[7:0], 8'h01);
        check("m_n_done",  n_done, 1);
        check("m_extra",   extra, 0);
        check("m_rx_hold", ctrl_d.rx_reg, 8'h88);

        // Async reset after the 10th rise
        sel = 1'b0;
        rises = 0; prev = 1'b0; extra = 0;
        drive(24'h000814, 1'b1);
        for (int c = 0; c < 300 && rises < 10; c++) begin
            @(negedge clk);
            drive(24'h000814, 1'b0);
            if (sclk_d && !prev) rises++;
            prev = sclk_d;
        end
        check("ar_reached", rises, 10);
        rst_n = 1'b0;
        #1;
        check("ar_csb",  csb_d, 1);
        check("ar_sclk", sclk_d, 0);
        check("ar_sdt",  sdt_d, 1);
        check("ar_rx",   ctrl_d.rx_reg, 0);
        repeat (2) begin
            @(negedge clk);
            if (ctrl_d.transfer_done) extra++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 250; c++) begin
            @(negedge clk);
            if (ctrl_d.transfer_done || ctrl_d.busy) extra++;
        end
        check("ar_no_done", extra, 0);
        run_frame(1'b0, 24'h000814, 8'h00, 0, rises, cap, done_cyc, n_done, t_err, rx, csb, gap);
        check("ar_w_data",     cap[15:0], 16'h0814);
        check("ar_w_done_cyc", done_cyc, 197);

        // Fast configuration read returning 0xA5
        run_frame(1'b1, {ad_instr(1'b1, AD_ADDR_CHIP_ID), 8'h00}, 8'hA5, 0,
                  rises, cap, done_cyc, n_done, t_err, rx, csb, gap);
        check("f_rises",    rises, 24);
        check("f_sdt",      t_err, 0);
        check("f_rx",       rx, 8'hA5);
        check("f_done_cyc", done_cyc, 51);

        // Back-to-back writes: second start the cycle after the first done
        run_frame(1'b0, {ad_instr(1'b0, AD_ADDR_TRANSFER), 8'h01}, 8'h00, 0,
                  rises, cap, done_cyc, n_done, t_err, rx, csb, gap);
        check("b2b_first_done", done_cyc, 197);
        run_frame(1'b0, 24'h000814, 8'h00, 0, rises, cap, done_cyc, n_done, t_err, rx, csb, gap);
        check("b2b_gap",      gap, 1);
        check("b2b_data",     cap[15:0], 16'h0814);
        check("b2b_done_cyc", done_cyc, 197);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
